// File: rtl/pmod_pkg.sv
// ---------------------------------------------------------------------------
// pmod_pkg
// Shared constants and types for the PMOD button debounce stage.
//   DEBOUNCE_DEFAULT   : stable cycles before a level is accepted (1 ms @ 12 MHz)
//   IPORT_*_LSB        : bit offsets of the fields packed into the input-port word
//   MAX_CHANNELS       : widest button bank the iport layout can hold
//   filt_state_e       : per-channel filter state (STABLE / PENDING)
// ---------------------------------------------------------------------------
package pmod_pkg;

  localparam int DEBOUNCE_DEFAULT  = 12000;
  localparam int IPORT_STATE_LSB   = 0;
  localparam int IPORT_PRESS_LSB   = 8;
  localparam int IPORT_RELEASE_LSB = 16;
  localparam int MAX_CHANNELS      = 8;

  typedef enum logic {
    FILT_STABLE  = 1'b0,
    FILT_PENDING = 1'b1
  } filt_state_e;

endpackage

// File: rtl/debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// One button channel: 2-flop synchronizer, stability counter and the
// accepted (debounced) level. Emits single-cycle rise/fall pulses on the
// same cycle the level register is updated.
//   clk, reset : system clock, async active-high reset
//   raw_i      : raw asynchronous button level
//   level_o    : debounced level
//   rise_o     : pulses high in the cycle a 0->1 change is accepted
//   fall_o     : pulses high in the cycle a 1->0 change is accepted
// ---------------------------------------------------------------------------
module debounce_bit
  import pmod_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  filt_state_e   state_q, state_d;

  // Two-flop synchronizer; only s2_q is allowed to feed the filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Filter state, counter and accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILT_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // The counter tracks how many consecutive cycles s2 has disagreed with the
  // accepted level. The cycle it reaches CNT_LAST with the disagreement still
  // present is the DEBOUNCE-th such cycle, so the new level is taken there and
  // the counter never needs to go past CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_o  = 1'b0;
    fall_o  = 1'b0;
    case (state_q)
      FILT_STABLE: begin
        cnt_d = '0;
        if (s2_q != level_q) begin
          state_d = FILT_PENDING;
          cnt_d   = CW'(1);
        end
      end
      FILT_PENDING: begin
        if (s2_q == level_q) begin
          state_d = FILT_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FILT_STABLE;
          cnt_d   = '0;
          level_d = s2_q;
          rise_o  = s2_q;
          fall_o  = ~s2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign level_o = level_q;

endmodule

// File: rtl/pmod_btn_debounce.sv
// ---------------------------------------------------------------------------
// pmod_btn_debounce
// Debounce and event capture for the PMOD buttons. Each channel is filtered
// by a debounce_bit; this level keeps sticky press/release flags (cleared by
// a write-1-to-clear strobe), the interrupt OR and the packed input-port word.
//   clk, reset  : system clock, async active-high reset
//   btn_raw     : raw asynchronous button levels (active high)
//   evt_clr     : W1C strobe, clears both flags of the selected channels
//   btn_state   : debounced levels
//   press_evt   : sticky 0->1 flags
//   release_evt : sticky 1->0 flags
//   irq         : high while any flag is set
//   iport       : {release_evt @16, press_evt @8, btn_state @0}, rest zero
// ---------------------------------------------------------------------------
module pmod_btn_debounce
  import pmod_pkg::*;
#(
  parameter int N        = 4,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_raw,
  input  logic [N-1:0] evt_clr,
  output logic [N-1:0] btn_state,
  output logic [N-1:0] press_evt,
  output logic [N-1:0] release_evt,
  output logic         irq,
  output logic [31:0]  iport
);

  logic [N-1:0] rise, fall;
  logic [N-1:0] press_q, press_d;
  logic [N-1:0] release_q, release_d;

  // One independent filter per button.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    debounce_bit #(
      .DEBOUNCE (DEBOUNCE)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (btn_raw[gi]),
      .level_o (btn_state[gi]),
      .rise_o  (rise[gi]),
      .fall_o  (fall[gi])
    );
  end

  // Set is ORed in after the clear so a new edge beats a simultaneous clear.
  always_comb begin
    press_d   = (press_q   & ~evt_clr) | rise;
    release_d = (release_q & ~evt_clr) | fall;
  end

  // Sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_evt   = press_q;
  assign release_evt = release_q;
  assign irq         = (|press_q) | (|release_q);

  // Pack the registered fields into the input-port word.
  always_comb begin
    iport = '0;
    iport[IPORT_STATE_LSB   +: N] = btn_state;
    iport[IPORT_PRESS_LSB   +: N] = press_q;
    iport[IPORT_RELEASE_LSB +: N] = release_q;
  end

endmodule

// File: tb/tb_pmod_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_pmod_btn_debounce
// Self-checking bench for pmod_btn_debounce with N=4, DEBOUNCE=4.
// The reference model keeps a short history of raw samples and accepts a new
// level once the samples that have crossed the synchronizer all disagree with
// the current level for DEBOUNCE consecutive cycles.
// ---------------------------------------------------------------------------
module tb_pmod_btn_debounce;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btnRaw;
  logic [N-1:0] evtClr;
  logic [N-1:0] btnState;
  logic [N-1:0] pressEvt;
  logic [N-1:0] releaseEvt;
  logic         irq;
  logic [31:0]  iport;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] mLevel, mPress, mRel;
  logic [N-1:0] hist[$];

  pmod_btn_debounce #(
    .N        (N),
    .DEBOUNCE (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btnRaw),
    .evt_clr     (evtClr),
    .btn_state   (btnState),
    .press_evt   (pressEvt),
    .release_evt (releaseEvt),
    .irq         (irq),
    .iport       (iport)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expIport();
    return {8'h00, 4'h0, mRel, 4'h0, mPress, 4'h0, mLevel};
  endfunction

  function automatic logic expIrq();
    return (|mPress) | (|mRel);
  endfunction

  task automatic modelReset();
    mLevel = '0;
    mPress = '0;
    mRel   = '0;
    hist.delete();
  endtask

  // Advance one clock: update the model with the inputs seen at the posedge,
  // then return at the following negedge where outputs are sampled and new
  // inputs are driven.
  task automatic tick();
    logic [N-1:0] rise, fall;
    bit           allDiff;
    @(posedge clk);
    if (reset) begin
      modelReset();
    end else begin
      hist.push_front(btnRaw);
      if (hist.size() > D + 2) void'(hist.pop_back());
      rise = '0;
      fall = '0;
      if (hist.size() == D + 2) begin
        for (int ch = 0; ch < N; ch++) begin
          allDiff = 1'b1;
          for (int k = 2; k < D + 2; k++)
            if (hist[k][ch] == mLevel[ch]) allDiff = 1'b0;
          if (allDiff) begin
            if (mLevel[ch]) fall[ch] = 1'b1;
            else            rise[ch] = 1'b1;
          end
        end
      end
      mLevel = mLevel ^ (rise | fall);
      mPress = (mPress & ~evtClr) | rise;
      mRel   = (mRel   & ~evtClr) | fall;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    reset  = 1'b1;
    btnRaw = '0;
    evtClr = '0;
    modelReset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btnRaw = 4'hF;
    evtClr = '0;
    modelReset();
    #1;
    checks++;
    if (iport !== 32'h0 || irq !== 1'b0 || btnState !== 4'h0 || pressEvt !== 4'h0 || releaseEvt !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: iport=%h irq=%b state=%h press=%h rel=%h, expected all 0",
               iport, irq, btnState, pressEvt, releaseEvt);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      checks++;
      if (iport !== expIport()) begin
        errors++;
        $display("[TB] FAIL reset_model cyc%0d: iport=%h expected %h", cyc, iport, expIport());
      end
      if (cyc == 5) begin
        checks++;
        if (iport !== 32'h0) begin
          errors++;
          $display("[TB] FAIL reset_early: iport=%h expected 00000000", iport);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (btnState !== 4'hF || pressEvt !== 4'hF || irq !== 1'b1 || iport !== 32'h0000_0F0F) begin
          errors++;
          $display("[TB] FAIL reset_capture: state=%h press=%h irq=%b iport=%h expected F F 1 00000F0F",
                   btnState, pressEvt, irq, iport);
        end
      end
    end
  endtask

  task automatic test_glitch();
    doReset();
    btnRaw[0] = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 3) btnRaw[0] = 1'b0;
      tick();
      checks++;
      if (btnState !== 4'h0 || pressEvt !== 4'h0 || irq !== 1'b0) begin
        errors++;
        $display("[TB] FAIL glitch cyc%0d: state=%h press=%h irq=%b expected 0 0 0",
                 cyc, btnState, pressEvt, irq);
      end
    end
  endtask

  task automatic test_press_release();
    doReset();
    btnRaw[1] = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      if (cyc == 5) begin
        checks++;
        if (btnState[1] !== 1'b0 || pressEvt[1] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL press_early: state1=%b press1=%b expected 0 0", btnState[1], pressEvt[1]);
        end
      end
    end
    checks++;
    if (btnState[1] !== 1'b1 || pressEvt[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL press_edge: state1=%b press1=%b expected 1 1", btnState[1], pressEvt[1]);
    end
    btnRaw[1] = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) tick();
    checks++;
    if (releaseEvt[1] !== 1'b1 || iport !== 32'h0002_0200) begin
      errors++;
      $display("[TB] FAIL release_edge: rel1=%b iport=%h expected 1 00020200", releaseEvt[1], iport);
    end
  endtask

  task automatic test_clear();
    // Clearing a channel whose flags are already clear changes nothing.
    evtClr = 4'b0001;
    tick();
    evtClr = '0;
    checks++;
    if (iport !== 32'h0002_0200) begin
      errors++;
      $display("[TB] FAIL clear_noop: iport=%h expected 00020200", iport);
    end
    evtClr = 4'b0010;
    tick();
    evtClr = '0;
    checks++;
    if (pressEvt !== 4'h0 || releaseEvt !== 4'h0 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_w1c: press=%h rel=%h irq=%b expected 0 0 0", pressEvt, releaseEvt, irq);
    end
    btnRaw[2] = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) tick();
    evtClr[2] = 1'b1;
    tick();
    evtClr = '0;
    checks++;
    if (pressEvt[2] !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_set_wins: press2=%b irq=%b expected 1 1", pressEvt[2], irq);
    end
    checks++;
    if (iport !== expIport()) begin
      errors++;
      $display("[TB] FAIL clear_model: iport=%h expected %h", iport, expIport());
    end
  endtask

  task automatic test_mid_reset();
    doReset();
    btnRaw = 4'b0001;
    for (int cyc = 1; cyc <= 6; cyc++) tick();
    btnRaw = 4'b1001;
    for (int cyc = 1; cyc <= 4; cyc++) tick();
    checks++;
    if (iport !== expIport() || iport === 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_pre: iport=%h expected %h", iport, expIport());
    end
    reset = 1'b1;
    modelReset();
    #1;
    checks++;
    if (iport !== 32'h0 || irq !== 1'b0 || btnState !== 4'h0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: iport=%h irq=%b state=%h expected 0", iport, irq, btnState);
    end
    tick();
    reset = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) tick();
    checks++;
    if (pressEvt !== 4'b1001 || btnState !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL midreset_fresh: press=%h state=%h expected 9 9", pressEvt, btnState);
    end
  endtask

  task automatic test_bounce();
    doReset();
    for (int t = 0; t < 10; t++) begin
      btnRaw[2] = ~btnRaw[2];
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (pressEvt[2] !== 1'b0 || btnState[2] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bounce_train: press2=%b state2=%b expected 0 0", pressEvt[2], btnState[2]);
        end
      end
    end
    btnRaw[2] = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      checks++;
      if (pressEvt[2] !== (cyc >= 6) || releaseEvt[2] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce_settle cyc%0d: press2=%b rel2=%b expected %b 0",
                 cyc, pressEvt[2], releaseEvt[2], (cyc >= 6));
      end
    end
  endtask

  task automatic test_random();
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, 6) == 0) btnRaw[ch] = ~btnRaw[ch];
        evtClr[ch] = ($urandom_range(0, 9) == 0);
      end
      tick();
      checks++;
      if (iport !== expIport() || irq !== expIrq()) begin
        errors++;
        $display("[TB] FAIL random cyc%0d: iport=%h irq=%b expected %h %b",
                 cyc, iport, irq, expIport(), expIrq());
      end
    end
    evtClr = '0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_clear();
    test_mid_reset();
    test_bounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmod_btn_debounce.md
# pmod_btn_debounce

Debounce and event-capture stage for the PMOD button inputs on the MAX1000 board. It sits between the PMOD button/LED adapter, which supplies raw active-high button levels, and the SoC input port. It synchronizes each raw button, filters bounce with a per-channel stability counter, and presents a packed 32-bit input-port word: debounced levels plus sticky press and release flags. Firmware clears the flags with a write-1-to-clear pulse, and the block raises one level interrupt while any flag is set.

## Interface
- `N`, default 4: number of button channels, 1..8.
- `DEBOUNCE`, default 12000: consecutive stable cycles required before a level is accepted. This is 1 ms at 12 MHz. Minimum 2.
- `clk`  in  1: system clock, the same clock the SoC is driven from.
- `reset`  in  1: asynchronous, active-high reset.
- `btn_raw`  in  N: raw button levels, asynchronous, active-high.
- `evt_clr`  in  N: single-cycle write-1-to-clear strobe for both the press and release flag of each channel.
- `btn_state`  out  N: debounced level per channel.
- `press_evt`  out  N: sticky flag, set on each debounced 0->1 transition.
- `release_evt`  out  N: sticky flag, set on each debounced 1->0 transition.
- `irq`  out  1: OR of all `press_evt` and `release_evt` bits.
- `iport`  out  32: packed word. `[N-1:0]` = `btn_state`, `[8+N-1:8]` = `press_evt`, `[16+N-1:16]` = `release_evt`. All other bits are 0.

## Operation
- **Reset values:** the synchronizer flops, counters, `btn_state`, `press_evt`, `release_evt`, `irq` and `iport` are all 0.
- **Synchronizer:** each channel uses a 2-flop synchronizer, `s1` then `s2`. Only `s2` is used downstream.
- **Per-channel counter:** width `$clog2(DEBOUNCE)`, behaving as a 2-state filter (STABLE / PENDING).
  - STABLE: `s2 == btn_state`. The counter holds 0.
  - `s2 != btn_state`: move to PENDING and count up each cycle while the mismatch persists.
  - Any cycle with `s2 == btn_state` in PENDING: counter returns to 0 and the channel goes back to STABLE. A glitch shorter than `DEBOUNCE` cycles produces no change.
  - On the cycle the counter equals `DEBOUNCE-1` with the mismatch still present: `btn_state <= s2`, counter <= 0, and the matching edge flag is set.
  - The counter never wraps; its maximum value is `DEBOUNCE-1`.
- **Flags:**
  - A flag is set on its debounced edge and cleared only by `evt_clr[i]` or by reset.
  - If set and clear hit the same channel in the same cycle, set wins and the flag stays 1.
  - `evt_clr` on a flag that is already clear has no effect.
  - A repeated edge while a flag is already set leaves it at 1; events are not counted.
- **Channels** are fully independent. Simultaneous transitions on several channels all capture in the same cycle.
- **Reset mid-operation:** all state clears immediately. If a button is still held after reset is released, it is debounced again from 0 and produces one fresh `press_evt`.

## Timing
- **Latency:** raw edge to `btn_state`/flag update is `DEBOUNCE+2` cycles. This is 2 synchronizer cycles plus `DEBOUNCE` counting cycles, assuming the raw input stays stable throughout.
- `btn_state`, the flags and `iport` are registered.
- `irq` is a combinational OR of registered flags, so it asserts in the same cycle a flag sets.
- Flag clear takes effect on the clock edge that samples `evt_clr`. `irq` deasserts in the following cycle if no other flag is set.
- No backpressure. `evt_clr` is a level sampled every cycle, and the SoC drives it as a 1-cycle pulse.

## Structure
- **Shared package `pmod_pkg`:** default `DEBOUNCE`, the field offsets `IPORT_STATE_LSB=0`, `IPORT_PRESS_LSB=8`, `IPORT_RELEASE_LSB=16`, and the maximum channel count 8.
- **Sub-module `debounce_bit`:** holds the synchronizer, counter and level register for one channel, and emits a 1-cycle `rise`/`fall` pulse. It is instantiated N times via generate.
- **Top level:** holds the sticky flags, the `irq` OR and the `iport` packing.

## Test plan
All scenarios use `DEBOUNCE=4`.
- **Reset:** assert reset with `btn_raw=4'hF` -> all outputs 0. Release reset and hold `btn_raw` -> at cycle 6 `btn_state=F`, `press_evt=F`, `irq=1`, `iport=32'h0000_0F0F`.
- **Glitch rejection:** pulse `btn_raw[0]` high for 3 cycles, then low -> `btn_state`, `press_evt` and `irq` stay 0 throughout.
- **Press/release:** set `btn_raw[1]=1` -> `btn_state[1]=1` and `press_evt[1]=1` exactly 6 cycles later. Clear `btn_raw[1]` -> `release_evt[1]=1` 6 cycles later, giving `iport=32'h0002_0200`.
- **Clear semantics:** pulse `evt_clr=4'b0010` -> both flags for channel 1 drop on the next edge and `irq=0`. Assert `evt_clr[2]` in the same cycle as a channel-2 press sets -> `press_evt[2]` stays 1.
- **Mid-operation reset:** assert reset while channel 3 has counter=2 in PENDING -> all outputs 0 immediately.
- **Bounce train:** toggle `btn_raw[2]` every 2 cycles for 20 cycles, then hold 1 -> exactly one `press_evt[2]`, 6 cycles after the final stable edge.
